hvsync_generator: RTL and testbench
===================================

Name: hvsync_generator

Overview:
- VGA 640x480@60 Hz timing generator, one pixel per clock.
- Produces hsync/vsync, the display-enable flag, and the current pixel coordinates.
- Sits at the top of the video pipeline and feeds the pixel renderer and the TinyVGA PMOD output mapping.

Parameters:
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, visible lines per frame.
- V_BOTTOM, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_TOP, 33, vertical back porch (lines).
- SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync pulses are driven low.

Ports:
- clk  in  1  pixel clock; all logic rises on its posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- hsync  out  1  horizontal sync, registered.
- vsync  out  1  vertical sync, registered.
- display_on  out  1  high while the current (hpos,vpos) is inside the visible area.
- hpos  out  10  current pixel column, range 0..H_MAX.
- vpos  out  10  current line, range 0..V_MAX.

Behaviour:
- Derived constants:
  - H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 = 799.
  - H_SYNC_START = H_DISPLAY+H_FRONT = 656; H_SYNC_END = H_SYNC_START+H_SYNC-1 = 751.
  - V_MAX = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP-1 = 524.
  - V_SYNC_START = V_DISPLAY+V_BOTTOM = 490; V_SYNC_END = 491.
- Reset (rst_n low, asynchronous): hpos=0, vpos=0, internal sync-active flags=0, so hsync=vsync=1 (inactive).
  - Outputs hold these values until the first posedge with rst_n high.
  - Reset asserted mid-frame takes effect immediately; there is no partial-line recovery.
- hpos counter:
  - Increments by 1 every clock.
  - When hpos==H_MAX, the next value is 0 (the "line end" event).
- vpos counter:
  - Changes only on a line end.
  - Increments on a line end; when vpos==V_MAX at a line end, the next value is 0.
  - Frame length = 800*525 = 420000 clocks.
- Sync generation:
  - hsync active on the clock after every cycle in which H_SYNC_START<=hpos<=H_SYNC_END. It is registered from the pre-increment hpos, so it lags by 1 clock.
  - With defaults, hsync is low while hpos reads 657..752 and high otherwise.
  - vsync active on the clock after every cycle in which V_SYNC_START<=vpos<=V_SYNC_END, registered from the current vpos.
  - Output polarity: active value = ~SYNC_ACTIVE_LOW.
- display_on: combinational, (hpos<H_DISPLAY)&&(vpos<V_DISPLAY); no extra latency versus hpos/vpos.
- Widths:
  - Counters are 10 bit and never exceed their MAX values.
  - Comparisons are unsigned.
  - No other state exists; no handshakes; runs free forever.

Decomposition:
- Package vga_timing_pkg holds:
  - all default timing values;
  - derived H_MAX/V_MAX and sync start/end localparams;
  - counter width (10).
- One natural sub-module, vga_axis_counter (parameterised MAX, SYNC_START, SYNC_END, with an increment-enable input and a wrap output), instantiated twice:
  - horizontal: enable tied high;
  - vertical: enabled by the horizontal wrap.

Test Plan:
- Reset: hold rst_n=0 over several clocks, with one assertion between edges -> hpos=0, vpos=0, hsync=1, vsync=1 immediately; after release, hpos=1 after the first edge.
- Line wrap: run 799 clocks from reset -> hpos=799, vpos=0; next edge -> hpos=0, vpos=1.
- Frame wrap: run 419999 clocks -> hpos=799, vpos=524; next edge -> hpos=0, vpos=0.
- hsync timing on line 0:
  - hsync falls on the edge where hpos becomes 657 and stays low exactly 96 clocks;
  - it rises when hpos becomes 753.
- vsync timing:
  - vsync goes low one clock after vpos becomes 490 (hpos=1);
  - it stays low for 2*800 clocks;
  - it returns high one clock after vpos becomes 492.
- display_on boundaries:
  - (639,0)=1, (640,0)=0, (0,479)=1, (0,480)=0, (799,524)=0.
  - Count over one frame = 307200 high cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
//------------------------------------------------------------------------------
// Module : vga_timing_pkg
// Brief  : Default 640x480@60 Hz timing values, derived limits, coordinate type.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

    localparam int COUNT_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;

    localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

    localparam int DEF_H_MAX        = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK - 1;
    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;

    localparam int DEF_V_MAX        = DEF_V_DISPLAY + DEF_V_BOTTOM + DEF_V_SYNC + DEF_V_TOP - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_BOTTOM;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    typedef logic [COUNT_W-1:0] coord_t;

    // Inclusive unsigned window test used for both sync pulses.
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
//------------------------------------------------------------------------------
// Module : vga_axis_counter
// Brief  : One timing axis: wrapping position counter plus registered sync pulse.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX             = DEF_H_MAX,
    parameter int SYNC_START      = DEF_H_SYNC_START,
    parameter int SYNC_END        = DEF_H_SYNC_END,
    parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    output coord_t pos_o,
    output logic   wrap_o,
    output logic   sync_o
);

    localparam coord_t C_MAX        = coord_t'(MAX);
    localparam coord_t C_SYNC_START = coord_t'(SYNC_START);
    localparam coord_t C_SYNC_END   = coord_t'(SYNC_END);

    coord_t pos_q;
    coord_t pos_d;
    logic   sync_act_q;
    logic   sync_act_d;

    always_comb begin
        wrap_o = en_i && (pos_q == C_MAX);
        pos_d  = pos_q;
        if (wrap_o) begin
            pos_d = '0;
        end else if (en_i) begin
            pos_d = pos_q + 1'b1;
        end
        // Sampled from the pre-update position every clock, so the pulse lags by one.
        sync_act_d = in_window(pos_q, C_SYNC_START, C_SYNC_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            sync_act_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            sync_act_q <= sync_act_d;
        end
    end

    assign pos_o  = pos_q;
    assign sync_o = sync_act_q ^ SYNC_ACTIVE_LOW;

endmodule

`default_nettype wire

// File: rtl/hvsync_generator.sv
//------------------------------------------------------------------------------
// Module : hvsync_generator
// Brief  : VGA timing generator: sync pulses, display enable and pixel position.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hvsync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY       = DEF_H_DISPLAY,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_DISPLAY       = DEF_V_DISPLAY,
    parameter int V_BOTTOM        = DEF_V_BOTTOM,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_TOP           = DEF_V_TOP,
    parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [COUNT_W-1:0] hpos,
    output logic [COUNT_W-1:0] vpos
);

    localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_MAX        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam coord_t C_H_DISPLAY = coord_t'(H_DISPLAY);
    localparam coord_t C_V_DISPLAY = coord_t'(V_DISPLAY);

    logic h_wrap;
    logic v_wrap_unused;

    vga_axis_counter #(
        .MAX             (H_MAX),
        .SYNC_START      (H_SYNC_START),
        .SYNC_END        (H_SYNC_END),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .pos_o  (hpos),
        .wrap_o (h_wrap),
        .sync_o (hsync)
    );

    // Lines advance only at the end of each horizontal sweep.
    vga_axis_counter #(
        .MAX             (V_MAX),
        .SYNC_START      (V_SYNC_START),
        .SYNC_END        (V_SYNC_END),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (h_wrap),
        .pos_o  (vpos),
        .wrap_o (v_wrap_unused),
        .sync_o (vsync)
    );

    assign display_on = (hpos < C_H_DISPLAY) && (vpos < C_V_DISPLAY);

endmodule

`default_nettype wire

// File: tb/tb_hvsync_generator.sv
//------------------------------------------------------------------------------
// Module : tb_hvsync_generator
// Brief  : Self-checking bench: full-size and reduced-size timing instances.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hvsync_generator;

    localparam int S_HD = 20, S_HF = 3, S_HS = 5, S_HB = 4;
    localparam int S_VD = 12, S_VB = 2, S_VS = 2, S_VT = 3;

    typedef struct packed {
        logic [31:0] t;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        de;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hs_d, vs_d, de_d, hs_s, vs_s, de_s;
    logic [9:0] hp_d, vp_d, hp_s, vp_s;

    int unsigned t;
    bit          mon_en = 1'b0;
    int          passed = 0;
    int          total  = 0;

    vec_t tab_def [10];
    vec_t tab_sm  [16];

    hvsync_generator u_dut_def (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hs_d),
        .vsync      (vs_d),
        .display_on (de_d),
        .hpos       (hp_d),
        .vpos       (vp_d)
    );

    hvsync_generator #(
        .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_DISPLAY (S_VD), .V_BOTTOM(S_VB), .V_SYNC (S_VS), .V_TOP  (S_VT),
        .SYNC_ACTIVE_LOW (1'b0)
    ) u_dut_sm (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync      (hs_s),
        .vsync      (vs_s),
        .display_on (de_s),
        .hpos       (hp_s),
        .vpos       (vp_s)
    );

    always #5 clk = ~clk;

    // Clocks elapsed since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    // Expected outputs after tt clocks, from the frame arithmetic alone.
    function automatic logic [22:0] model(input int unsigned tt,
                                          input int hd, input int hf, input int hsw, input int hb,
                                          input int vd, input int vb, input int vsw, input int vt,
                                          input bit al);
        int  ht, vtot, h, v, ph, pv;
        bit  hact, vact, de;
        ht   = hd + hf + hsw + hb;
        vtot = vd + vb + vsw + vt;
        h    = int'(tt % ht);
        v    = int'((tt / ht) % vtot);
        hact = 1'b0;
        vact = 1'b0;
        if (tt > 0) begin
            ph   = int'((tt - 1) % ht);
            pv   = int'(((tt - 1) / ht) % vtot);
            hact = (ph >= hd + hf) && (ph < hd + hf + hsw);
            vact = (pv >= vd + vb) && (pv < vd + vb + vsw);
        end
        de = (h < hd) && (v < vd);
        return {10'(h), 10'(v), hact ^ al, vact ^ al, de};
    endfunction

    function automatic logic [22:0] model_def(input int unsigned tt);
        return model(tt, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
    endfunction

    function automatic logic [22:0] model_sm(input int unsigned tt);
        return model(tt, S_HD, S_HF, S_HS, S_HB, S_VD, S_VB, S_VS, S_VT, 1'b0);
    endfunction

    function automatic string fmt(input logic [22:0] x);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b de=%b", x[22:13], x[12:3], x[2], x[1], x[0]);
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s t=%0d: got %s, want %s", name, t, fmt(act), fmt(exp));
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_def", {hp_d, vp_d, hs_d, vs_d, de_d}, model_def(t));
            check("mon_sm",  {hp_s, vp_s, hs_s, vs_s, de_s}, model_sm(t));
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowc, dec, first_low, first_rise, vsc, hsc;
        int unsigned nrun;

        tab_def[0] = '{32'd0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1};
        tab_def[1] = '{32'd1,   10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
        tab_def[2] = '{32'd639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
        tab_def[3] = '{32'd640, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0};
        tab_def[4] = '{32'd656, 10'd656, 10'd0, 1'b1, 1'b1, 1'b0};
        tab_def[5] = '{32'd657, 10'd657, 10'd0, 1'b0, 1'b1, 1'b0};
        tab_def[6] = '{32'd752, 10'd752, 10'd0, 1'b0, 1'b1, 1'b0};
        tab_def[7] = '{32'd753, 10'd753, 10'd0, 1'b1, 1'b1, 1'b0};
        tab_def[8] = '{32'd799, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0};
        tab_def[9] = '{32'd800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1};

        tab_sm[0]  = '{32'd0,   10'd0,  10'd0,  1'b0, 1'b0, 1'b1};
        tab_sm[1]  = '{32'd19,  10'd19, 10'd0,  1'b0, 1'b0, 1'b1};
        tab_sm[2]  = '{32'd20,  10'd20, 10'd0,  1'b0, 1'b0, 1'b0};
        tab_sm[3]  = '{32'd24,  10'd24, 10'd0,  1'b1, 1'b0, 1'b0};
        tab_sm[4]  = '{32'd28,  10'd28, 10'd0,  1'b1, 1'b0, 1'b0};
        tab_sm[5]  = '{32'd29,  10'd29, 10'd0,  1'b0, 1'b0, 1'b0};
        tab_sm[6]  = '{32'd31,  10'd31, 10'd0,  1'b0, 1'b0, 1'b0};
        tab_sm[7]  = '{32'd32,  10'd0,  10'd1,  1'b0, 1'b0, 1'b1};
        tab_sm[8]  = '{32'd352, 10'd0,  10'd11, 1'b0, 1'b0, 1'b1};
        tab_sm[9]  = '{32'd384, 10'd0,  10'd12, 1'b0, 1'b0, 1'b0};
        tab_sm[10] = '{32'd448, 10'd0,  10'd14, 1'b0, 1'b0, 1'b0};
        tab_sm[11] = '{32'd449, 10'd1,  10'd14, 1'b0, 1'b1, 1'b0};
        tab_sm[12] = '{32'd512, 10'd0,  10'd16, 1'b0, 1'b1, 1'b0};
        tab_sm[13] = '{32'd513, 10'd1,  10'd16, 1'b0, 1'b0, 1'b0};
        tab_sm[14] = '{32'd607, 10'd31, 10'd18, 1'b0, 1'b0, 1'b0};
        tab_sm[15] = '{32'd608, 10'd0,  10'd0,  1'b0, 1'b0, 1'b1};

        // Reset held over several clocks.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_def", {hp_d, vp_d, hs_d, vs_d, de_d}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        check("rst_sm",  {hp_s, vp_s, hs_s, vs_s, de_s}, {10'd0, 10'd0, 1'b0, 1'b0, 1'b1});

        // Reset asserted between edges takes effect at once.
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_def", {hp_d, vp_d, hs_d, vs_d, de_d}, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        check("async_rst_sm",  {hp_s, vp_s, hs_s, vs_s, de_s}, {10'd0, 10'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            while (t < tab_def[i].t) @(negedge clk);
            check($sformatf("tab_def[%0d]", i), {hp_d, vp_d, hs_d, vs_d, de_d},
                  {tab_def[i].h, tab_def[i].v, tab_def[i].hs, tab_def[i].vs, tab_def[i].de});
        end

        // Line 1 of the full-size instance: hsync pulse width and visible span.
        lowc = 0; dec = 0; first_low = -1; first_rise = -1;
        for (int i = 0; i < 800; i++) begin
            if (!hs_d) begin
                lowc++;
                if (first_low < 0) first_low = int'(t);
            end else if (first_low >= 0 && first_rise < 0) begin
                first_rise = int'(t);
            end
            if (de_d) dec++;
            @(negedge clk);
        end
        check_int("hsync_low_clocks", lowc, 96);
        check_int("hsync_fall_t", first_low, 800 + 657);
        check_int("hsync_rise_t", first_rise, 800 + 753);
        check_int("line_display_clocks", dec, 640);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            while (t < tab_sm[i].t) @(negedge clk);
            check($sformatf("tab_sm[%0d]", i), {hp_s, vp_s, hs_s, vs_s, de_s},
                  {tab_sm[i].h, tab_sm[i].v, tab_sm[i].hs, tab_sm[i].vs, tab_sm[i].de});
        end

        // One whole reduced frame: display, vsync and hsync activity totals.
        dec = 0; vsc = 0; hsc = 0;
        for (int i = 0; i < 608; i++) begin
            if (de_s) dec++;
            if (vs_s) vsc++;
            if (hs_s) hsc++;
            @(negedge clk);
        end
        check_int("frame_display_clocks", dec, S_HD * S_VD);
        check_int("frame_vsync_clocks", vsc, S_VS * 32);
        check_int("frame_hsync_clocks", hsc, S_HS * 19);

        // Random run lengths with occasional asynchronous resets.
        mon_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            nrun = $urandom_range(50, 1500);
            repeat (nrun) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #($urandom_range(1, 4)) rst_n = 1'b0;
                #1;
                check("rnd_rst_def", {hp_d, vp_d, hs_d, vs_d, de_d}, model_def(0));
                check("rnd_rst_sm",  {hp_s, vp_s, hs_s, vs_s, de_s}, model_sm(0));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
